// File: rtl/cpu_pkg.sv
// Shared register-file widths and the writeback-queue entry layout used by
// the writeback queue and its FIFO storage.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
    logic                  live;
  } wbq_entry_t;
endpackage

// File: rtl/wbq_fifo.sv
// Circular FIFO of long-latency writebacks with per-entry live bits, WAW kill
// compare against the issuing pipeline write, and a hazard query port.
module wbq_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_dest,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill,
  input  logic [REG_ADDR_W-1:0] kill_dest,
  input  logic [REG_ADDR_W-1:0] q_reg,
  output logic                  head_live,
  output logic [REG_ADDR_W-1:0] head_dest,
  output logic [DATA_W-1:0]     head_data,
  output logic                  q_pending,
  output logic [CNT_W-1:0]      count
);

  wbq_entry_t       mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [DEPTH-1:0] live_next, kill_hit, q_hit;
  logic             push_live;
  wbq_entry_t       head_entry;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign kill_hit[gi] = kill && mem_reg[gi].live && (mem_reg[gi].dest == kill_dest);
      assign q_hit[gi]    = mem_reg[gi].live && (mem_reg[gi].dest == q_reg);
    end
  endgenerate

  // A result arriving alongside a same-register pipeline write is older in
  // program order, so it enters the queue already dead.
  assign push_live = !(kill && (push_dest == kill_dest));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live_next[i] = mem_reg[i].live && !kill_hit[i];
    end
    if (pop) live_next[rd_ptr_reg] = 1'b0;
    if (push) live_next[wr_ptr_reg] = push_live;
  end

  always_comb begin
    count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Payload fields have no reset; only the live bits gate any use of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_reg[i].live <= startin ? 1'b0 : live_next[i];
    end
    if (push && !startin) begin
      mem_reg[wr_ptr_reg].dest <= push_dest;
      mem_reg[wr_ptr_reg].data <= push_data;
    end
  end

  assign head_entry = mem_reg[rd_ptr_reg];
  assign head_live  = head_entry.live && (count_reg != '0);
  assign head_dest  = head_entry.dest;
  assign head_data  = head_entry.data;
  assign q_pending  = (q_reg != '0) && (|q_hit);
  assign count      = count_reg;

endmodule

// File: rtl/writeback_queue.sv
// Register-file write port arbiter: pipeline writes take priority, long-latency
// results wait in a small FIFO and drain on otherwise idle cycles.
module writeback_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  lu_valid,
  output logic                  lu_ready,
  input  logic [REG_ADDR_W-1:0] lu_reg,
  input  logic [DATA_W-1:0]     lu_data,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  input  logic [REG_ADDR_W-1:0] q_reg,
  output logic                  q_pending,
  output logic [CNT_W-1:0]      count
);

  logic                  wb_issue, lu_push, fifo_pop;
  logic                  head_live;
  logic [REG_ADDR_W-1:0] head_dest;
  logic [DATA_W-1:0]     head_data;

  logic                  regwrite_reg, regwrite_next;
  logic [REG_ADDR_W-1:0] writereg_reg, writereg_next;
  logic [DATA_W-1:0]     writedata_reg, writedata_next;

  assign wb_issue = !startin && wb_valid && (wb_reg != '0);
  assign lu_ready = !startin && (count < CNT_W'(DEPTH));
  assign lu_push  = lu_valid && lu_ready && (lu_reg != '0);
  // Dead heads still pop so physical occupancy drains at one entry per cycle.
  assign fifo_pop = !startin && !wb_issue && (count != '0);

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .startin   (startin),
    .push      (lu_push),
    .push_dest (lu_reg),
    .push_data (lu_data),
    .pop       (fifo_pop),
    .kill      (wb_issue),
    .kill_dest (wb_reg),
    .q_reg     (q_reg),
    .head_live (head_live),
    .head_dest (head_dest),
    .head_data (head_data),
    .q_pending (q_pending),
    .count     (count)
  );

  always_comb begin
    regwrite_next  = 1'b0;
    writereg_next  = writereg_reg;
    writedata_next = writedata_reg;
    if (wb_issue) begin
      regwrite_next  = 1'b1;
      writereg_next  = wb_reg;
      writedata_next = wb_data;
    end else if (fifo_pop && head_live) begin
      regwrite_next  = 1'b1;
      writereg_next  = head_dest;
      writedata_next = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (startin) begin
      regwrite_reg  <= 1'b0;
      writereg_reg  <= '0;
      writedata_reg <= '0;
    end else begin
      regwrite_reg  <= regwrite_next;
      writereg_reg  <= writereg_next;
      writedata_reg <= writedata_next;
    end
  end

  assign RegWrite  = regwrite_reg;
  assign WriteReg  = writereg_reg;
  assign WriteData = writedata_reg;

endmodule
